// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit that produces a HI/LO pair for the register file.
// Latency: start is sampled in cycle 0, then XLEN CALC cycles, then a one-cycle hi_lo_wen in cycle XLEN+1.
// Backpressure: none; busy stalls EX, start is ignored while busy, and flush aborts with no write.
//
// Ports:
//   clk, resetn     clock and asynchronous active-low reset
//   start, op       request (sampled only in IDLE); op 0=MULT 1=MULTU 2=DIV 3=DIVU
//   src1, src2      multiplicand/dividend and multiplier/divisor, latched with start
//   flush           abort the operation in flight; gates hi_lo_wen in the same cycle
//   busy            high in CALC and DONE
//   hi_lo_wen       one-cycle write strobe for HI/LO
//   hi_wdata        product upper half or remainder
//   lo_wdata        product lower half or quotient
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            busy,
    output logic            hi_lo_wen,
    output logic [XLEN-1:0] hi_wdata,
    output logic [XLEN-1:0] lo_wdata
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operation context captured at start.
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             neg_res;    // negate the product or the quotient
    logic             neg_rem;    // negate the remainder (the dividend was negative)
    logic             div_zero;
    logic [XLEN-1:0]  opnd;       // |multiplicand| for a multiply, |divisor| for a divide
    logic [XLEN-1:0]  acc_hi;     // partial product high half / partial remainder
    logic [XLEN-1:0]  acc_lo;     // multiplier bits being shifted out / quotient being shifted in

    // Decode of the incoming request.
    logic            op_div;
    logic            op_signed;
    logic            sign1;
    logic            sign2;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            accept;
    logic            last_step;

    // One iteration of the datapath.
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic [XLEN-1:0] step_hi;
    logic [XLEN-1:0] step_lo;

    // Sign-corrected final result.
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fin_hi;
    logic [XLEN-1:0]   fin_lo;

    assign op_div    = op[1];
    assign op_signed = ~op[0];
    assign sign1     = op_signed & src1[XLEN-1];
    assign sign2     = op_signed & src2[XLEN-1];
    // Two's complement negation also gives the right unsigned magnitude for the most negative value.
    assign mag1      = sign1 ? (~src1 + 1'b1) : src1;
    assign mag2      = sign2 ? (~src2 + 1'b1) : src2;

    assign accept    = (state == S_IDLE) && start && !flush;
    assign last_step = (state == S_CALC) && (cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and outputs. hi_lo_wen is a decode of DONE; flush is its only input-side gating.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        hi_lo_wen = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !flush) begin
                    state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                hi_lo_wen = !flush;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Multiply is shift-add on {acc_hi, acc_lo}: the multiplier's low bit selects the add and the
    // 65-bit result shifts right one place. Divide is restoring: shift the next dividend bit into
    // the remainder, try to subtract, and keep the difference only when it is non-negative.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(XLEN + 1){1'b0}});
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        step_hi   = mul_sum[XLEN:1];
        step_lo   = {mul_sum[0], acc_lo[XLEN-1:1]};
        if (is_div) begin
            if (!div_diff[XLEN]) begin
                step_hi = div_diff[XLEN-1:0];
                step_lo = {acc_lo[XLEN-2:0], 1'b1};
            end else begin
                step_hi = div_shift[XLEN-1:0];
                step_lo = {acc_lo[XLEN-2:0], 1'b0};
            end
        end
    end

    // The final result is built from the last iteration's output so that it can be registered
    // on the edge that enters DONE.
    // With a zero divisor every trial subtraction succeeds, so the remainder is |src1|. Applying
    // the dividend sign restores the original src1. Only the quotient needs forcing to all ones.
    always_comb begin
        prod     = {step_hi, step_lo};
        prod_fix = neg_res ? (~prod + 1'b1) : prod;
        quo_fix  = neg_res ? (~step_lo + 1'b1) : step_lo;
        rem_fix  = neg_rem ? (~step_hi + 1'b1) : step_hi;
        if (is_div) begin
            fin_hi = rem_fix;
            fin_lo = div_zero ? {XLEN{1'b1}} : quo_fix;
        end else begin
            fin_hi = prod_fix[2*XLEN-1:XLEN];
            fin_lo = prod_fix[XLEN-1:0];
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            hi_wdata <= '0;
            lo_wdata <= '0;
        end else begin
            if (accept) begin
                cnt      <= '0;
                is_div   <= op_div;
                neg_res  <= sign1 ^ sign2;
                neg_rem  <= op_div & sign1;
                div_zero <= op_div & (src2 == '0);
                acc_hi   <= '0;
                if (op_div) begin
                    opnd   <= mag2;
                    acc_lo <= mag1;
                end else begin
                    opnd   <= mag1;
                    acc_lo <= mag2;
                end
            end else if (state == S_CALC) begin
                cnt    <= cnt + CNT_W'(1);
                acc_hi <= step_hi;
                acc_lo <= step_lo;
            end

            // A flush in the final CALC cycle suppresses the update along with the write.
            if (last_step && !flush) begin
                hi_wdata <= fin_hi;
                lo_wdata <= fin_lo;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        busy;
    logic        hi_lo_wen;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;
    logic [31:0] last_hi;
    logic [31:0] last_lo;
    vec_t        vecs[11];

    muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .busy      (busy),
        .hi_lo_wen (hi_lo_wen),
        .hi_wdata  (hi_wdata),
        .lo_wdata  (lo_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, want);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one cycle; returns in cycle 1 (first CALC cycle).
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src1  = a;
        src2  = b;
        sync();
        start = 1'b0;
    endtask

    // Counts busy cycles at negedges until busy drops (bounded), then re-aligns after posedge.
    task automatic wait_idle(output int n);
        int guard;
        n     = 0;
        guard = 0;
        do begin
            @(negedge clk);
            if (busy) n++;
            guard++;
        end while (busy && guard < 200);
        sync();
    endtask

    task automatic run_op(input vec_t v, input string name);
        int n0;
        int n;
        issue(v.op, v.a, v.b);
        exp_q.push_back({v.hi, v.lo});
        @(negedge clk);
        chk({name, "_hold_during_calc"}, {hi_wdata, lo_wdata}, {last_hi, last_lo});
        n0 = busy ? 1 : 0;
        last_hi = v.hi;
        last_lo = v.lo;
        wait_idle(n);
        chk({name, "_busy_cycles"}, 64'(n0 + n), 64'd33);
    endtask

    // Scoreboard monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resetn && hi_lo_wen) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got hi=%h lo=%h with no result outstanding", hi_wdata, lo_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result", {hi_wdata, lo_wdata}, mon_e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cnt;
        int wen_cnt;
        int wen_cyc;
        int hold_bad;
        int n;

        vecs[0]  = '{OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[2]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[3]  = '{OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
        vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[6]  = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[7]  = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8]  = '{OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[9]  = '{OP_MULT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};
        vecs[10] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};

        resetn = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        op     = 2'd0;
        src1   = 32'd0;
        src2   = 32'd0;
        last_hi = 32'd0;
        last_lo = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {30'd0, busy, hi_lo_wen, hi_wdata}, 64'd0);
        chk("reset_lo", {32'd0, lo_wdata}, 64'd0);
        resetn = 1'b1;
        sync();

        // MULTU with exact cycle accounting: strobe in cycle 33 only, busy in cycles 1..33.
        issue(OP_MULTU, 32'h0000_FFFF, 32'h0001_0000);
        exp_q.push_back({32'h0000_0000, 32'hFFFF_0000});
        busy_cnt = 0;
        wen_cnt  = 0;
        wen_cyc  = 0;
        hold_bad = 0;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (hi_lo_wen) begin
                wen_cnt++;
                wen_cyc = c;
            end
            if (c <= 32 && (hi_wdata !== 32'd0 || lo_wdata !== 32'd0)) hold_bad++;
        end
        chk("multu_wen_cycle", 64'(wen_cyc), 64'd33);
        chk("multu_wen_count", 64'(wen_cnt), 64'd1);
        chk("multu_busy_cycles", 64'(busy_cnt), 64'd33);
        chk("multu_calc_hold", 64'(hold_bad), 64'd0);
        chk("multu_busy_after", {63'd0, busy}, 64'd0);
        last_hi = 32'h0000_0000;
        last_lo = 32'hFFFF_0000;
        sync();

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Flush in cycle 10 of DIVU 9/3: no strobe, results kept, new start in cycle 11 accepted.
        issue(OP_DIVU, 32'd9, 32'd3);
        repeat (9) sync();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_busy_in_c10", {63'd0, busy}, 64'd1);
        sync();
        flush = 1'b0;
        chk("flush_busy_c11", {63'd0, busy}, 64'd0);
        chk("flush_results_kept", {hi_wdata, lo_wdata}, {last_hi, last_lo});
        run_op('{OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42}, "after_flush");

        // A start pulse in the middle of CALC must be ignored.
        issue(OP_DIVU, 32'd100, 32'd7);
        exp_q.push_back({32'd2, 32'd14});
        last_hi = 32'd2;
        last_lo = 32'd14;
        repeat (4) sync();
        start = 1'b1;
        op    = OP_MULTU;
        src1  = 32'd3;
        src2  = 32'd3;
        sync();
        start = 1'b0;
        wait_idle(n);
        chk("ignored_start_busy", 64'(n), 64'd28);

        // Flush while in DONE gates the strobe in the same cycle.
        issue(OP_MULTU, 32'd2, 32'd3);
        repeat (32) sync();
        flush = 1'b1;
        #1;
        chk("done_flush_wen", {63'd0, hi_lo_wen}, 64'd0);
        chk("done_flush_busy", {63'd0, busy}, 64'd1);
        sync();
        flush = 1'b0;
        chk("done_flush_idle", {63'd0, busy}, 64'd0);

        // Reset in cycle 15 of a MULT: outputs clear at once and no strobe follows.
        issue(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (14) sync();
        resetn = 1'b0;
        #1;
        chk("midop_reset_ctl", {62'd0, busy, hi_lo_wen}, 64'd0);
        chk("midop_reset_data", {hi_wdata, lo_wdata}, 64'd0);
        last_hi = 32'd0;
        last_lo = 32'd0;
        sync();
        sync();
        resetn = 1'b1;
        repeat (40) sync();
        chk("post_reset_idle", {63'd0, busy}, 64'd0);

        run_op('{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001}, "post_reset");

        repeat (2) sync();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
